// File: rtl/muldiv_sequencer_if.sv
// Issue/result bundle between the decode stage and the mul/div sequencer.
//
// Handshake: `issue` is the valid and `~stall` is the ready. An instruction in
// `op`/`a`/`b` transfers on a rising edge where issue=1 and stall=0. While
// stall=1 the instruction is not consumed, and the issuer must hold it. Results
// (`result`, `hi`, `lo`) and status (`busy`, `done`) are plain level outputs.
interface muldiv_sequencer_if;
  logic [6:0]  op;
  logic        issue;
  logic [31:0] a;
  logic [31:0] b;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output op, issue, a, b,
    input  stall, busy, done, result, hi, lo
  );

  modport slave (
    input  op, issue, a, b,
    output stall, busy, done, result, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative 32-step multiply/divide engine that owns the HI/LO pair.
// Signed operands are reduced to magnitudes on accept. The sign corrections and
// the divide-by-zero/overflow overrides are applied in a single FIX cycle.
module muldiv_sequencer (
  input  logic                  clk,
  input  logic                  reset_n,
  muldiv_sequencer_if.slave     bus,
  output logic [1:0]            fsm_state
);

  localparam logic [6:0] OP_DIV   = 7'd7;
  localparam logic [6:0] OP_DIVU  = 7'd8;
  localparam logic [6:0] OP_MFHI  = 7'd9;
  localparam logic [6:0] OP_MFLO  = 7'd10;
  localparam logic [6:0] OP_MTHI  = 7'd11;
  localparam logic [6:0] OP_MTLO  = 7'd12;
  localparam logic [6:0] OP_MULT  = 7'd13;
  localparam logic [6:0] OP_MULTU = 7'd14;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q;      // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [31:0] opnd_q;     // mul: multiplicand magnitude; div: divisor magnitude
  logic        is_div_q;
  logic        neg_res_q;
  logic        neg_rem_q;
  logic        dz_q;
  logic        ovf_q;
  logic [31:0] hi_q, lo_q;
  logic        done_q;

  logic        known_op, md_op, div_op, signed_op;
  logic        busy, stall;
  logic        accept_md, accept_mthi, accept_mtlo;
  logic        last_step;
  logic [31:0] abs_a, abs_b;
  logic [32:0] add_sum;
  logic [63:0] mul_next;
  logic [32:0] trial;
  logic [63:0] div_next;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;
  logic [31:0] hi_fix, lo_fix;

  // Decode of the issued opcode and the issue handshake.
  always_comb begin
    known_op    = (bus.op >= OP_DIV) && (bus.op <= OP_MULTU);
    md_op       = (bus.op == OP_MULT) || (bus.op == OP_MULTU) ||
                  (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    div_op      = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    signed_op   = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    busy        = (state_q != S_IDLE);
    stall       = bus.issue && known_op && busy;
    accept_md   = bus.issue && !stall && md_op && (state_q == S_IDLE);
    accept_mthi = bus.issue && !stall && (bus.op == OP_MTHI) && (state_q == S_IDLE);
    accept_mtlo = bus.issue && !stall && (bus.op == OP_MTLO) && (state_q == S_IDLE);
    abs_a       = (signed_op && bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
    abs_b       = (signed_op && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;
  end

  // Step datapath: one shift-add or one restoring-divide step per cycle.
  always_comb begin
    add_sum  = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
    mul_next = acc_q[0] ? {add_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
    // The shifted partial remainder is 33 bits wide; bit 32 of the difference is the borrow.
    trial    = acc_q[63:31] - {1'b0, opnd_q};
    div_next = trial[32] ? {acc_q[62:0], 1'b0} : {trial[31:0], acc_q[30:0], 1'b1};
  end

  // Sign correction and special-case overrides applied in FIX.
  always_comb begin
    prod_fix = neg_res_q ? (~acc_q + 64'd1) : acc_q;
    quot_fix = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem_fix  = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    hi_fix   = prod_fix[63:32];
    lo_fix   = prod_fix[31:0];
    if (is_div_q) begin
      if (dz_q) begin
        // A zero divisor leaves |a| in the remainder; restoring the sign yields a.
        hi_fix = rem_fix;
        lo_fix = 32'hFFFF_FFFF;
      end else if (ovf_q) begin
        hi_fix = 32'd0;
        lo_fix = 32'h8000_0000;
      end else begin
        hi_fix = rem_fix;
        lo_fix = quot_fix;
      end
    end
  end

  // Next-state logic of the sequencer.
  always_comb begin
    state_d   = state_q;
    last_step = (cnt_q == 5'd31);
    case (state_q)
      S_IDLE:       if (accept_md) state_d = div_op ? S_DIV : S_MUL;
      S_MUL, S_DIV: if (last_step) state_d = S_FIX;
      S_FIX:        state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // State register and the registered done pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == S_FIX);
    end
  end

  // Operand latch on accept and the per-cycle iteration.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q     <= 5'd0;
      acc_q     <= 64'd0;
      opnd_q    <= 32'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (accept_md) begin
      cnt_q     <= 5'd0;
      acc_q     <= {32'd0, (div_op ? abs_a : abs_b)};
      opnd_q    <= div_op ? abs_b : abs_a;
      is_div_q  <= div_op;
      neg_res_q <= signed_op && (bus.a[31] ^ bus.b[31]);
      neg_rem_q <= (bus.op == OP_DIV) && bus.a[31];
      dz_q      <= div_op && (bus.b == 32'd0);
      ovf_q     <= (bus.op == OP_DIV) && (bus.a == 32'h8000_0000) && (bus.b == 32'hFFFF_FFFF);
    end else if (state_q == S_MUL) begin
      acc_q <= mul_next;
      cnt_q <= cnt_q + 5'd1;
    end else if (state_q == S_DIV) begin
      acc_q <= div_next;
      cnt_q <= cnt_q + 5'd1;
    end
  end

  // Architectural HI/LO: written by FIX or by MTHI/MTLO (only possible when idle).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (state_q == S_FIX) begin
      hi_q <= hi_fix;
      lo_q <= lo_fix;
    end else begin
      if (accept_mthi) hi_q <= bus.a;
      if (accept_mtlo) lo_q <= bus.a;
    end
  end

  assign bus.stall  = stall;
  assign bus.busy   = busy;
  assign bus.done   = done_q;
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;
  assign bus.result = (bus.op == OP_MFHI) ? hi_q :
                      (bus.op == OP_MFLO) ? lo_q : 32'd0;
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed corner cases plus randomized mul/div
// traffic checked against an arithmetic reference model.
module tb_muldiv_sequencer;

  localparam logic [6:0] OP_DIV   = 7'd7;
  localparam logic [6:0] OP_DIVU  = 7'd8;
  localparam logic [6:0] OP_MFHI  = 7'd9;
  localparam logic [6:0] OP_MFLO  = 7'd10;
  localparam logic [6:0] OP_MTHI  = 7'd11;
  localparam logic [6:0] OP_MTLO  = 7'd12;
  localparam logic [6:0] OP_MULT  = 7'd13;
  localparam logic [6:0] OP_MULTU = 7'd14;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] fsm_state;
  int         checks = 0;
  int         errors = 0;
  logic [63:0] exp_q[$];

  muldiv_sequencer_if bus();

  muldiv_sequencer dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .fsm_state(fsm_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model: {HI, LO} straight from the arithmetic definition.
  function automatic logic [63:0] ref_model(input logic [6:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy;
    logic signed [31:0] q, r;
    sx = $signed({{32{x[31]}}, x});
    sy = $signed({{32{y[31]}}, y});
    case (o)
      OP_MULTU: return {32'd0, x} * {32'd0, y};
      OP_MULT:  return sx * sy;
      OP_DIVU: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      OP_DIV: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
        return {r, q};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Driver: present an instruction at a falling edge (accepted at the next rising edge).
  task automatic start_op(input logic [6:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    bus.op = o;
    bus.a = x;
    bus.b = y;
    bus.issue = 1'b1;
    #1;
  endtask

  // Driver: advance cycles after accept until done; lat = cycle index of done or -1.
  // With probe set, MFLO is issued every cycle and stall=1 cycles within 1..33 are counted.
  task automatic wait_done(input bit probe, output int lat, output int stall_cnt);
    lat = -1;
    stall_cnt = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      bus.a = $urandom;
      bus.b = $urandom;
      if (probe) begin
        bus.op = OP_MFLO;
        bus.issue = 1'b1;
      end else begin
        bus.op = 7'd0;
        bus.issue = 1'b0;
      end
      #1;
      if (probe && cyc <= 33 && bus.stall === 1'b1) stall_cnt++;
      if (bus.done === 1'b1) begin
        lat = cyc;
        break;
      end
    end
  endtask

  // Driver: full mul/div op; returns HI/LO as seen in the done cycle.
  task automatic run_op(input logic [6:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output logic [31:0] h, output logic [31:0] l);
    int sc;
    start_op(o, x, y);
    wait_done(1'b0, lat, sc);
    h = bus.hi;
    l = bus.lo;
  endtask

  task automatic test_reset;
    bus.op = 7'd0;
    bus.issue = 1'b0;
    bus.a = 32'd0;
    bus.b = 32'd0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    bus.op = OP_MFHI;
    bus.issue = 1'b1;
    #1;
    checks++;
    if (bus.result !== 32'd0) begin errors++; $display("FAIL reset_mfhi: got %h expected %h", bus.result, 32'd0); end
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL reset_status: busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
    bus.op = OP_MFLO;
    #1;
    checks++;
    if (bus.result !== 32'd0) begin errors++; $display("FAIL reset_mflo: got %h expected %h", bus.result, 32'd0); end
    bus.issue = 1'b0;
  endtask

  task automatic test_multu_timing;
    int lat, sc;
    start_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL multu_accept_stall: got %b expected 0", bus.stall); end
    wait_done(1'b1, lat, sc);
    checks++;
    if (lat != 34) begin errors++; $display("FAIL multu_latency: got %0d expected 34", lat); end
    checks++;
    if (sc != 33) begin errors++; $display("FAIL multu_mflo_stall: stalled %0d cycles expected 33", sc); end
    checks++;
    if (bus.stall !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL multu_done_cycle: stall=%b busy=%b expected 0 0", bus.stall, bus.busy);
    end
    checks++;
    if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001) begin
      errors++; $display("FAIL multu_result: got %h_%h expected fffffffe_00000001", bus.hi, bus.lo);
    end
    checks++;
    if (bus.result !== 32'h0000_0001) begin errors++; $display("FAIL multu_mflo: got %h expected 00000001", bus.result); end
    @(negedge clk);
    bus.issue = 1'b0;
    bus.op = 7'd0;
    #1;
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL done_width: got %b expected 0", bus.done); end
  endtask

  task automatic test_mult;
    int lat;
    logic [31:0] h, l;
    run_op(OP_MULT, 32'hFFFF_FFF9, 32'd3, lat, h, l);
    checks++;
    if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFEB) begin
      errors++; $display("FAIL mult_neg: got %h_%h expected ffffffff_ffffffeb", h, l);
    end
    checks++;
    if (lat != 34) begin errors++; $display("FAIL mult_latency: got %0d expected 34", lat); end
  endtask

  task automatic test_div;
    int lat;
    logic [31:0] h, l;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, h, l);
    checks++;
    if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL div_signed: got %h_%h expected ffffffff_fffffffd", h, l);
    end
    // MFHI in the done cycle sees the new HI without stalling.
    bus.op = OP_MFHI;
    bus.issue = 1'b1;
    #1;
    checks++;
    if (bus.stall !== 1'b0 || bus.result !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL mfhi_done_cycle: stall=%b result=%h expected 0 ffffffff", bus.stall, bus.result);
    end
    run_op(OP_DIVU, 32'd100, 32'd7, lat, h, l);
    checks++;
    if (h !== 32'd2 || l !== 32'd14) begin errors++; $display("FAIL divu_basic: got %h_%h expected 00000002_0000000e", h, l); end
  endtask

  task automatic test_corner_div;
    int lat;
    logic [31:0] h, l;
    logic [63:0] e;
    run_op(OP_DIVU, 32'd5, 32'd0, lat, h, l);
    checks++;
    if (h !== 32'd5 || l !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_by_zero: got %h_%h expected 00000005_ffffffff", h, l); end
    checks++;
    if (lat != 34) begin errors++; $display("FAIL div0_latency: got %0d expected 34", lat); end
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, h, l);
    checks++;
    if (h !== 32'd0 || l !== 32'h8000_0000) begin errors++; $display("FAIL div_overflow: got %h_%h expected 00000000_80000000", h, l); end
    e = ref_model(OP_DIV, 32'hFFFF_FFF9, 32'd0);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd0, lat, h, l);
    checks++;
    if ({h, l} !== e) begin errors++; $display("FAIL div_neg_by_zero: got %h_%h expected %h", h, l, e); end
  endtask

  task automatic test_mthi;
    start_op(OP_MTHI, 32'h1234_5678, 32'd0);
    @(negedge clk);
    bus.op = OP_MFHI;
    #1;
    checks++;
    if (bus.result !== 32'h1234_5678) begin errors++; $display("FAIL mthi_mfhi: got %h expected 12345678", bus.result); end
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL mthi_status: busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
    bus.op = OP_MTLO;
    bus.a = 32'hCAFE_F00D;
    @(negedge clk);
    bus.op = OP_MFLO;
    #1;
    checks++;
    if (bus.result !== 32'hCAFE_F00D) begin errors++; $display("FAIL mtlo_mflo: got %h expected cafef00d", bus.result); end
    bus.issue = 1'b0;
  endtask

  task automatic test_stall_rules;
    int lat, sc;
    start_op(OP_MULTU, 32'd6, 32'd7);
    @(negedge clk);
    bus.op = 7'd3;
    bus.issue = 1'b1;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL unknown_op_stall: got %b expected 0", bus.stall); end
    bus.op = OP_MFHI;
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin errors++; $display("FAIL mfhi_busy_stall: got %b expected 1", bus.stall); end
    bus.op = OP_MTHI;
    bus.a = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin errors++; $display("FAIL mthi_busy_stall: got %b expected 1", bus.stall); end
    wait_done(1'b0, lat, sc);
    checks++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd42 || lat != 33) begin
      errors++; $display("FAIL stalled_mthi_ignored: got %h_%h lat %0d expected 00000000_0000002a lat 33", bus.hi, bus.lo, lat);
    end
  endtask

  task automatic test_reset_mid;
    int lat, seen;
    logic [31:0] h, l;
    start_op(OP_DIVU, 32'd1000, 32'd3);
    repeat (10) begin
      @(negedge clk);
      bus.issue = 1'b0;
      bus.op = 7'd0;
    end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      errors++; $display("FAIL reset_mid_state: busy=%b hi=%h lo=%h expected 0 0 0", bus.busy, bus.hi, bus.lo);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (bus.done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL reset_mid_no_done: got %0d pulses expected 0", seen); end
    run_op(OP_MULTU, 32'd3, 32'd4, lat, h, l);
    checks++;
    if (h !== 32'd0 || l !== 32'd12 || lat != 34) begin
      errors++; $display("FAIL after_reset_multu: got %h_%h lat %0d expected 00000000_0000000c lat 34", h, l, lat);
    end
  endtask

  task automatic test_back_to_back;
    int lat, sc;
    logic [6:0]  o;
    logic [31:0] x, y;
    logic [63:0] e;
    o = OP_MULT; x = $urandom; y = $urandom;
    exp_q.push_back(ref_model(o, x, y));
    start_op(o, x, y);
    for (int n = 0; n < 4; n++) begin
      wait_done(1'b0, lat, sc);
      e = exp_q.pop_front();
      checks++;
      if ({bus.hi, bus.lo} !== e || lat != 34) begin
        errors++; $display("FAIL b2b_result[%0d]: got %h_%h lat %0d expected %h lat 34", n, bus.hi, bus.lo, lat, e);
      end
      if (n < 3) begin
        o = (n % 2 == 0) ? OP_DIV : OP_MULTU;
        x = $urandom; y = $urandom_range(1, 1000);
        exp_q.push_back(ref_model(o, x, y));
        bus.op = o; bus.a = x; bus.b = y; bus.issue = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin errors++; $display("FAIL b2b_accept[%0d]: stall %b expected 0", n, bus.stall); end
      end
    end
  endtask

  task automatic test_random;
    int lat;
    logic [31:0] h, l, x, y;
    logic [6:0]  o;
    logic [63:0] e;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0: o = OP_MULT;
        1: o = OP_MULTU;
        2: o = OP_DIV;
        default: o = OP_DIVU;
      endcase
      x = $urandom;
      case ($urandom_range(0, 4))
        0: y = 32'd0;
        1: y = 32'hFFFF_FFFF;
        2: y = $urandom_range(1, 20);
        default: y = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) x = 32'h8000_0000;
      exp_q.push_back(ref_model(o, x, y));
      run_op(o, x, y, lat, h, l);
      e = exp_q.pop_front();
      checks++;
      if ({h, l} !== e || lat != 34) begin
        errors++; $display("FAIL random[%0d] op %0d a %h b %h: got %h_%h lat %0d expected %h lat 34", i, o, x, y, h, l, lat, e);
      end
    end
  endtask

  // Test sequence and final report.
  initial begin
    test_reset;
    test_multu_timing;
    test_mult;
    test_div;
    test_corner_div;
    test_mthi;
    test_stall_rules;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
